// File: rtl/tlul_pkg.sv
// TL-UL opcode constants and arbiter state encoding shared by the UART arbiter slice.
package tlul_pkg;

   localparam logic [2:0] OP_PUT_FULL_DATA   = 3'd0;
   localparam logic [2:0] OP_GET             = 3'd4;
   localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_RESP  = 3'd2,
      ST_ERR   = 3'd3,
      ST_DRAIN = 3'd4
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or above ptr, wrapping modulo N.
module rr_picker #(
   parameter int unsigned N  = 2,
   parameter int unsigned GW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] ptr,
   output logic [GW-1:0] idx,
   output logic          found
);

   logic [N-1:0] rot;

   // Rotate requests so ptr lands on bit 0, then take the lowest set bit.
   always_comb begin
      rot   = N'({req, req} >> ptr);
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            idx   = GW'((32'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/tlul_uart_arbiter.sv
// N-to-1 TL-UL arbiter in front of the tlul_uart slave: round-robin, one
// outstanding transaction, combinational A/D pass-through once granted.
module tlul_uart_arbiter
   import tlul_pkg::*;
#(
   parameter int unsigned N       = 2,
   parameter int unsigned W       = 4,
   parameter int unsigned A       = 32,
   parameter int unsigned Z       = 4,
   parameter int unsigned O       = 5,
   parameter int unsigned I       = 5,
   parameter int unsigned TIMEOUT = 1024,
   localparam int unsigned GW     = (N > 1) ? $clog2(N) : 1,
   localparam int unsigned DW     = 8 * W
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [N*3-1:0]  m_a_opcode,
   input  logic [N*3-1:0]  m_a_param,
   input  logic [N*Z-1:0]  m_a_size,
   input  logic [N*O-1:0]  m_a_source,
   input  logic [N*A-1:0]  m_a_address,
   input  logic [N*W-1:0]  m_a_mask,
   input  logic [N*DW-1:0] m_a_data,
   input  logic [N-1:0]    m_a_valid,
   output logic [N-1:0]    m_a_ready,
   output logic [2:0]      m_d_opcode,
   output logic [1:0]      m_d_param,
   output logic [Z-1:0]    m_d_size,
   output logic [O-1:0]    m_d_source,
   output logic [I-1:0]    m_d_sink,
   output logic [DW-1:0]   m_d_data,
   output logic            m_d_error,
   output logic [N-1:0]    m_d_valid,
   input  logic [N-1:0]    m_d_ready,
   output logic [2:0]      s_a_opcode,
   output logic [2:0]      s_a_param,
   output logic [Z-1:0]    s_a_size,
   output logic [O-1:0]    s_a_source,
   output logic [A-1:0]    s_a_address,
   output logic [W-1:0]    s_a_mask,
   output logic [DW-1:0]   s_a_data,
   output logic            s_a_valid,
   input  logic            s_a_ready,
   input  logic [2:0]      s_d_opcode,
   input  logic [1:0]      s_d_param,
   input  logic [Z-1:0]    s_d_size,
   input  logic [O-1:0]    s_d_source,
   input  logic [I-1:0]    s_d_sink,
   input  logic [DW-1:0]   s_d_data,
   input  logic            s_d_error,
   input  logic            s_d_valid,
   output logic            s_d_ready,
   output logic [GW-1:0]   grant,
   output logic            busy
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   logic [2:0]    a_opcode_arr [N];
   logic [2:0]    a_param_arr  [N];
   logic [Z-1:0]  a_size_arr   [N];
   logic [O-1:0]  a_source_arr [N];
   logic [A-1:0]  a_address_arr[N];
   logic [W-1:0]  a_mask_arr   [N];
   logic [DW-1:0] a_data_arr   [N];

   arb_state_e    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic [GW-1:0] grant_inc;
   logic [15:0]   cnt_q, cnt_d;
   logic [Z-1:0]  size_q, size_d;
   logic [O-1:0]  source_q, source_d;
   logic [GW-1:0] pick_idx;
   logic          pick_found;

   // Split the flat per-master A-channel buses into indexable slices.
   for (genvar k = 0; k < N; k++) begin : g_unpack
      assign a_opcode_arr[k]  = m_a_opcode[k*3 +: 3];
      assign a_param_arr[k]   = m_a_param[k*3 +: 3];
      assign a_size_arr[k]    = m_a_size[k*Z +: Z];
      assign a_source_arr[k]  = m_a_source[k*O +: O];
      assign a_address_arr[k] = m_a_address[k*A +: A];
      assign a_mask_arr[k]    = m_a_mask[k*W +: W];
      assign a_data_arr[k]    = m_a_data[k*DW +: DW];
   end

   rr_picker #(.N(N), .GW(GW)) u_picker (
      .req   (m_a_valid),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign grant_inc = (grant_q == GW'(N - 1)) ? '0 : grant_q + GW'(1);
   assign grant     = grant_q;
   assign busy      = (state_q != ST_IDLE);

   // State, ownership, timeout counter and captured request attributes.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         size_q   <= '0;
         source_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         size_q   <= size_d;
         source_q <= source_d;
      end
   end

   // Next-state: arbitrate, A handshake, D handshake or timeout, then drain.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      size_d   = size_q;
      source_d = source_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (!m_a_valid[grant_q]) begin
               state_d = ST_IDLE;
            end else if (s_a_ready) begin
               state_d  = ST_RESP;
               cnt_d    = '0;
               size_d   = a_size_arr[grant_q];
               source_d = a_source_arr[grant_q];
            end
         end
         ST_RESP: begin
            if (s_d_valid) begin
               if (m_d_ready[grant_q]) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = grant_inc;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d = ST_ERR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_ERR: begin
            if (m_d_ready[grant_q]) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (s_d_valid) begin
               state_d  = ST_IDLE;
               rr_ptr_d = grant_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Channel steering: only the owner sees ready/valid; ERR fabricates a response.
   always_comb begin
      s_a_opcode  = a_opcode_arr[grant_q];
      s_a_param   = a_param_arr[grant_q];
      s_a_size    = a_size_arr[grant_q];
      s_a_source  = a_source_arr[grant_q];
      s_a_address = a_address_arr[grant_q];
      s_a_mask    = a_mask_arr[grant_q];
      s_a_data    = a_data_arr[grant_q];
      s_a_valid   = 1'b0;
      m_a_ready   = '0;
      m_d_opcode  = s_d_opcode;
      m_d_param   = s_d_param;
      m_d_size    = s_d_size;
      m_d_source  = s_d_source;
      m_d_sink    = s_d_sink;
      m_d_data    = s_d_data;
      m_d_error   = s_d_error;
      m_d_valid   = '0;
      s_d_ready   = 1'b0;
      unique case (state_q)
         ST_ADDR: begin
            s_a_valid          = m_a_valid[grant_q];
            m_a_ready[grant_q] = s_a_ready;
         end
         ST_RESP: begin
            m_d_valid[grant_q] = s_d_valid;
            s_d_ready          = m_d_ready[grant_q];
         end
         ST_ERR: begin
            m_d_valid[grant_q] = 1'b1;
            m_d_opcode         = OP_ACCESS_ACK_DATA;
            m_d_param          = '0;
            m_d_size           = size_q;
            m_d_source         = source_q;
            m_d_sink           = '0;
            m_d_data           = '0;
            m_d_error          = 1'b1;
         end
         ST_DRAIN: begin
            s_d_ready = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tlul_uart_arbiter.sv
// Directed + randomized bench for tlul_uart_arbiter with a transaction-level model.
module tb_tlul_uart_arbiter;

   localparam int unsigned N       = 2;
   localparam int unsigned W       = 4;
   localparam int unsigned A       = 32;
   localparam int unsigned Z       = 4;
   localparam int unsigned O       = 5;
   localparam int unsigned I       = 5;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned GW      = 1;
   localparam int unsigned DW      = 32;

   logic            CLK;
   logic            RST_N;
   logic [N*3-1:0]  m_a_opcode, m_a_param;
   logic [N*Z-1:0]  m_a_size;
   logic [N*O-1:0]  m_a_source;
   logic [N*A-1:0]  m_a_address;
   logic [N*W-1:0]  m_a_mask;
   logic [N*DW-1:0] m_a_data;
   logic [N-1:0]    m_a_valid, m_a_ready;
   logic [2:0]      m_d_opcode;
   logic [1:0]      m_d_param;
   logic [Z-1:0]    m_d_size;
   logic [O-1:0]    m_d_source;
   logic [I-1:0]    m_d_sink;
   logic [DW-1:0]   m_d_data;
   logic            m_d_error;
   logic [N-1:0]    m_d_valid, m_d_ready;
   logic [2:0]      s_a_opcode, s_a_param;
   logic [Z-1:0]    s_a_size;
   logic [O-1:0]    s_a_source;
   logic [A-1:0]    s_a_address;
   logic [W-1:0]    s_a_mask;
   logic [DW-1:0]   s_a_data;
   logic            s_a_valid, s_a_ready;
   logic [2:0]      s_d_opcode;
   logic [1:0]      s_d_param;
   logic [Z-1:0]    s_d_size;
   logic [O-1:0]    s_d_source;
   logic [I-1:0]    s_d_sink;
   logic [DW-1:0]   s_d_data;
   logic            s_d_error, s_d_valid, s_d_ready;
   logic [GW-1:0]   grant;
   logic            busy;

   logic [2:0]    ta_op   [N];
   logic [2:0]    ta_param[N];
   logic [Z-1:0]  ta_size [N];
   logic [O-1:0]  ta_src  [N];
   logic [A-1:0]  ta_addr [N];
   logic [W-1:0]  ta_mask [N];
   logic [DW-1:0] ta_data [N];

   int checks = 0;
   int errors = 0;
   int model_rr = 0;

   for (genvar k = 0; k < N; k++) begin : g_pack
      assign m_a_opcode[k*3 +: 3]   = ta_op[k];
      assign m_a_param[k*3 +: 3]    = ta_param[k];
      assign m_a_size[k*Z +: Z]     = ta_size[k];
      assign m_a_source[k*O +: O]   = ta_src[k];
      assign m_a_address[k*A +: A]  = ta_addr[k];
      assign m_a_mask[k*W +: W]     = ta_mask[k];
      assign m_a_data[k*DW +: DW]   = ta_data[k];
   end

   tlul_uart_arbiter #(.N(N), .W(W), .A(A), .Z(Z), .O(O), .I(I), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
      .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
      .m_a_data(m_a_data), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
      .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
      .m_d_source(m_d_source), .m_d_sink(m_d_sink), .m_d_data(m_d_data),
      .m_d_error(m_d_error), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
      .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
      .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
      .s_a_data(s_a_data), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
      .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
      .s_d_source(s_d_source), .s_d_sink(s_d_sink), .s_d_data(s_d_data),
      .s_d_error(s_d_error), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
      .grant(grant), .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Round-robin rule: first requester at or after the pointer, wrapping.
   function automatic int model_pick(input logic [N-1:0] mask, input int rr);
      for (int i = 0; i < int'(N); i++) begin
         int k;
         logic [N-1:0] oh;
         k  = (rr + i) % int'(N);
         oh = N'(1) << k;
         if ((mask & oh) != '0) return k;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int k);
      return N'(1) << k;
   endfunction

   task automatic rand_master(input int k);
      ta_op[k]    = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd0;
      ta_param[k] = 3'd0;
      ta_size[k]  = Z'($urandom_range(0, 2));
      ta_src[k]   = O'($urandom);
      ta_addr[k]  = $urandom;
      ta_mask[k]  = W'($urandom);
      ta_data[k]  = $urandom;
   endtask

   task automatic apply_reset();
      RST_N     = 1'b0;
      m_a_valid = '0;
      s_a_ready = 1'b0;
      s_d_valid = 1'b0;
      m_d_ready = '0;
      tick();
      tick();
      RST_N    = 1'b1;
      model_rr = 0;
      #1;
   endtask

   // One complete transaction through the arbiter; called from IDLE.
   task automatic run_txn(input string tag, input logic [N-1:0] mask, input int a_dly,
                          input int r_dly, input int d_dly, input logic [DW-1:0] rdata);
      int w;
      logic [I-1:0] snk;
      w   = model_pick(mask, model_rr);
      snk = I'($urandom);
      m_a_valid = mask;
      s_a_ready = 1'b0;
      #1;
      chk({tag, "/idle_s_a_valid"}, 64'(s_a_valid), 64'(0));
      chk({tag, "/idle_m_a_ready"}, 64'(m_a_ready), 64'(0));
      tick();
      chk({tag, "/grant"}, 64'(grant), 64'(w));
      chk({tag, "/busy"}, 64'(busy), 64'(1));
      for (int c = 0; c < a_dly; c++) begin
         chk({tag, "/a_wait_valid"}, 64'(s_a_valid), 64'(1));
         chk({tag, "/a_wait_addr"}, 64'(s_a_address), 64'(ta_addr[w]));
         chk({tag, "/a_wait_data"}, 64'(s_a_data), 64'(ta_data[w]));
         chk({tag, "/a_wait_ready"}, 64'(m_a_ready), 64'(0));
         tick();
      end
      s_a_ready = 1'b1;
      #1;
      chk({tag, "/a_valid"}, 64'(s_a_valid), 64'(1));
      chk({tag, "/a_ready"}, 64'(m_a_ready), 64'(onehot(w)));
      chk({tag, "/a_addr"}, 64'(s_a_address), 64'(ta_addr[w]));
      chk({tag, "/a_op"}, 64'(s_a_opcode), 64'(ta_op[w]));
      chk({tag, "/a_src"}, 64'(s_a_source), 64'(ta_src[w]));
      chk({tag, "/a_size"}, 64'(s_a_size), 64'(ta_size[w]));
      chk({tag, "/a_mask"}, 64'(s_a_mask), 64'(ta_mask[w]));
      tick();
      s_a_ready = 1'b0;
      m_a_valid = m_a_valid & ~onehot(w);
      m_d_ready = '0;
      s_d_valid = 1'b0;
      for (int c = 0; c < r_dly; c++) begin
         #1;
         chk({tag, "/r_wait_d_valid"}, 64'(m_d_valid), 64'(0));
         chk({tag, "/r_wait_s_a_valid"}, 64'(s_a_valid), 64'(0));
         chk({tag, "/r_wait_a_ready"}, 64'(m_a_ready), 64'(0));
         tick();
      end
      s_d_valid  = 1'b1;
      s_d_data   = rdata;
      s_d_opcode = (ta_op[w] == 3'd4) ? 3'd1 : 3'd0;
      s_d_param  = 2'd0;
      s_d_size   = ta_size[w];
      s_d_source = ta_src[w];
      s_d_sink   = snk;
      s_d_error  = 1'b0;
      for (int c = 0; c < d_dly; c++) begin
         #1;
         chk({tag, "/d_wait_valid"}, 64'(m_d_valid), 64'(onehot(w)));
         chk({tag, "/d_wait_data"}, 64'(m_d_data), 64'(rdata));
         chk({tag, "/d_wait_s_d_ready"}, 64'(s_d_ready), 64'(0));
         tick();
      end
      m_d_ready = '1;
      #1;
      chk({tag, "/d_valid"}, 64'(m_d_valid), 64'(onehot(w)));
      chk({tag, "/d_ready"}, 64'(s_d_ready), 64'(1));
      chk({tag, "/d_data"}, 64'(m_d_data), 64'(rdata));
      chk({tag, "/d_src"}, 64'(m_d_source), 64'(ta_src[w]));
      chk({tag, "/d_sink"}, 64'(m_d_sink), 64'(snk));
      chk({tag, "/d_error"}, 64'(m_d_error), 64'(0));
      tick();
      s_d_valid = 1'b0;
      m_d_ready = '0;
      model_rr  = (w + 1) % int'(N);
      #1;
      chk({tag, "/done_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      int w;
      int n;
      for (int k = 0; k < int'(N); k++) rand_master(k);
      s_d_opcode = '0; s_d_param = '0; s_d_size = '0; s_d_source = '0;
      s_d_sink = '0; s_d_data = '0; s_d_error = 1'b0;

      // Reset state, with a request pending that must not be granted yet.
      apply_reset();
      RST_N = 1'b0;
      m_a_valid = 2'b01;
      #1;
      chk("reset/grant", 64'(grant), 64'(0));
      chk("reset/busy", 64'(busy), 64'(0));
      chk("reset/s_a_valid", 64'(s_a_valid), 64'(0));
      chk("reset/m_a_ready", 64'(m_a_ready), 64'(0));
      chk("reset/m_d_valid", 64'(m_d_valid), 64'(0));
      chk("reset/s_d_ready", 64'(s_d_ready), 64'(0));
      apply_reset();

      // Single Get from master 0 to address 127, response after 3 cycles.
      ta_op[0]   = 3'd4;
      ta_addr[0] = 32'd127;
      run_txn("single", 2'b01, 0, 3, 0, 32'h41);
      // Pointer moved to 1: with both requesting, master 1 wins.
      run_txn("rr_after_single", 2'b11, 1, 1, 0, $urandom);

      // Simultaneous requests held from reset: 0,1,0,1.
      apply_reset();
      for (int t = 0; t < 4; t++) begin
         chk("simul/model_order", 64'(model_pick(2'b11, model_rr)), 64'(t % 2));
         run_txn("simul", 2'b11, 0, 1, 0, $urandom);
      end

      // Backpressure on both A and D channels.
      run_txn("backpressure", 2'b10, 5, 2, 4, 32'hCAFE_F00D);

      // Timeout: slave never answers, synthetic error, late response drained.
      m_a_valid = 2'b01;
      w = model_pick(2'b01, model_rr);
      tick();
      s_a_ready = 1'b1;
      #1;
      chk("timeout/grant", 64'(grant), 64'(w));
      tick();
      s_a_ready  = 1'b0;
      m_a_valid  = '0;
      m_d_ready  = '0;
      s_d_data   = 32'hDEAD_BEEF;
      s_d_source = ~ta_src[w];
      s_d_error  = 1'b0;
      n = 0;
      while (m_d_valid == '0 && n < 100) begin
         tick();
         n++;
      end
      chk("timeout/latency", 64'(n), 64'(TIMEOUT));
      for (int c = 0; c < 3; c++) begin
         chk("timeout/err_valid", 64'(m_d_valid), 64'(onehot(w)));
         chk("timeout/err_error", 64'(m_d_error), 64'(1));
         chk("timeout/err_opcode", 64'(m_d_opcode), 64'(1));
         chk("timeout/err_param", 64'(m_d_param), 64'(0));
         chk("timeout/err_source", 64'(m_d_source), 64'(ta_src[w]));
         chk("timeout/err_size", 64'(m_d_size), 64'(ta_size[w]));
         chk("timeout/err_data", 64'(m_d_data), 64'(0));
         chk("timeout/err_sink", 64'(m_d_sink), 64'(0));
         chk("timeout/err_s_d_ready", 64'(s_d_ready), 64'(0));
         if (c < 2) tick();
      end
      m_d_ready = '1;
      tick();
      m_d_ready = '0;
      #1;
      chk("drain/busy", 64'(busy), 64'(1));
      chk("drain/s_d_ready", 64'(s_d_ready), 64'(1));
      chk("drain/m_d_valid", 64'(m_d_valid), 64'(0));
      tick();
      chk("drain/still_busy", 64'(busy), 64'(1));
      s_d_valid = 1'b1;
      s_d_data  = 32'h55;
      #1;
      chk("drain/not_forwarded", 64'(m_d_valid), 64'(0));
      tick();
      s_d_valid = 1'b0;
      model_rr  = (w + 1) % int'(N);
      #1;
      chk("drain/idle", 64'(busy), 64'(0));

      // Reset in the middle of a response.
      m_a_valid = 2'b01;
      w = model_pick(2'b01, model_rr);
      tick();
      s_a_ready = 1'b1;
      tick();
      s_a_ready = 1'b0;
      m_a_valid = '0;
      s_d_valid = 1'b1;
      m_d_ready = '0;
      #1;
      chk("midreset/pre_valid", 64'(m_d_valid), 64'(onehot(w)));
      RST_N = 1'b0;
      #1;
      chk("midreset/m_d_valid", 64'(m_d_valid), 64'(0));
      chk("midreset/s_a_valid", 64'(s_a_valid), 64'(0));
      chk("midreset/s_d_ready", 64'(s_d_ready), 64'(0));
      chk("midreset/busy", 64'(busy), 64'(0));
      chk("midreset/grant", 64'(grant), 64'(0));
      s_d_valid = 1'b0;
      tick();
      RST_N    = 1'b1;
      model_rr = 0;
      #1;
      run_txn("after_reset", 2'b10, 0, 2, 1, $urandom);

      // Master drops a_valid while in ADDR: back to IDLE, pointer untouched.
      m_a_valid = 2'b11;
      w = model_pick(2'b11, model_rr);
      tick();
      #1;
      chk("violation/grant", 64'(grant), 64'(w));
      chk("violation/s_a_valid", 64'(s_a_valid), 64'(1));
      m_a_valid = '0;
      #1;
      chk("violation/s_a_valid_low", 64'(s_a_valid), 64'(0));
      chk("violation/m_a_ready", 64'(m_a_ready), 64'(0));
      tick();
      chk("violation/idle", 64'(busy), 64'(0));
      run_txn("violation_retry", 2'b11, 0, 0, 0, $urandom);

      // Randomized traffic against the round-robin model.
      for (int t = 0; t < 30; t++) begin
         for (int k = 0; k < int'(N); k++) rand_master(k);
         run_txn("random", N'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tlul_uart_arbiter.md
Name: tlul_uart_arbiter

Overview:
- N-to-1 TileLink-UL arbiter that shares the single tlul_uart slave between N TL-UL masters, e.g. an echo master and a debug/console master.
- Round-robin grant with one outstanding transaction at a time.
- A-channel and D-channel pass through combinationally once granted.
- Sits between the masters and the tlul_uart instance in the top-level echo/SoC wrapper.

Parameters:
- N, 2, number of masters (2..8).
- W, 4, data bus width in bytes.
- A, 32, address width.
- Z, 4, size field width.
- O, 5, source ID width.
- I, 5, sink ID width.
- TIMEOUT, 1024, cycles to wait in RESP before a synthetic error response (16-bit counter, TIMEOUT <= 65535).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_mask, m_a_data  in  N*3, N*3, N*Z, N*O, N*A, N*W, N*8W  per-master A-channel fields; master k occupies slice k.
- m_a_valid  in  N  per-master A valid.
- m_a_ready  out  N  per-master A ready.
- m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_sink, m_d_data, m_d_error  out  3, 2, Z, O, I, 8W, 1  D-channel fields broadcast to all masters.
- m_d_valid  out  N  per-master D valid.
- m_d_ready  in  N  per-master D ready.
- s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address, s_a_mask, s_a_data  out  3, 3, Z, O, A, W, 8W  A-channel to the slave.
- s_a_valid  out  1  A valid to the slave.
- s_a_ready  in  1  A ready from the slave.
- s_d_opcode, s_d_param, s_d_size, s_d_source, s_d_sink, s_d_data, s_d_error  in  3, 2, Z, O, I, 8W, 1  D-channel from the slave.
- s_d_valid  in  1  D valid from the slave.
- s_d_ready  out  1  D ready to the slave.
- grant  out  $clog2(N)  index of the current owner.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST_N=0): state=IDLE, grant=0, rr_ptr=0, timeout counter=0. All valid/ready outputs 0; busy=0. Reset mid-transaction abandons it; no response is produced.
- IDLE:
  - If any m_a_valid is high, pick the first asserted index searching from rr_ptr upward, wrapping modulo N.
  - Register it in grant and go to ADDR next cycle. Arbitration costs 1 cycle of latency.
  - No ready/valid is asserted in IDLE.
- ADDR:
  - s_a_* = granted slice; s_a_valid = m_a_valid[grant]; m_a_ready[grant] = s_a_ready; other m_a_ready = 0.
  - On s_a_valid & s_a_ready: clear the counter and go to RESP.
  - If m_a_valid[grant] drops before the handshake (protocol violation): return to IDLE with rr_ptr unchanged.
- RESP:
  - m_d_* fields = s_d_*; m_d_valid[grant] = s_d_valid; s_d_ready = m_d_ready[grant]; other m_d_valid = 0.
  - s_a_valid = 0; all m_a_ready = 0.
  - On the D handshake: go to IDLE and set rr_ptr = (grant+1) mod N.
  - The counter increments each cycle s_d_valid is low. When it reaches TIMEOUT-1, go to ERR.
- ERR (synthetic response):
  - m_d_valid[grant] = 1; m_d_opcode = 1 (AccessAckData); m_d_param = 0.
  - m_d_size and m_d_source are the captured request size/source; m_d_sink = 0; m_d_data = 0; m_d_error = 1.
  - On m_d_ready[grant]: go to DRAIN.
- DRAIN:
  - s_d_ready = 1 to swallow exactly one late slave response; nothing is forwarded.
  - On s_d_valid: go to IDLE, advance rr_ptr.
- Request capture: size and source are registered at the A handshake, for ERR use.
- Simultaneous requests in IDLE: the round-robin pick is deterministic. A request arriving in the same cycle as the grant-register update waits for the next IDLE.
- s_d_valid in IDLE or ADDR (spurious): s_d_ready stays 0; the response is not consumed.
- N=1 degenerates to a registered pass-through with 1-cycle arbitration; grant width is clamped to 1.

Decomposition:
- Package tlul_pkg: TL-UL opcode constants (Get=4, PutFullData=0, AccessAck=0, AccessAckData=1) and the state enum {IDLE, ADDR, RESP, ERR, DRAIN}.
- Sub-module rr_picker (N-bit request vector plus pointer in, index and found out), combinational.

Test Plan:
1. Single request: master 0 issues Get to address 127, slave acks with data 0x41 after 3 cycles -> m_d_valid[0] with data 0x41; grant=0; rr_ptr becomes 1; m_a_ready[1] stays 0 throughout.
2. Simultaneous: both masters hold a_valid from reset -> grants in order 0,1,0,1 over four transactions; each completes before the next s_a_valid rises.
3. Backpressure: s_a_ready low 5 cycles, then m_d_ready[1] low 4 cycles -> no duplicate handshake; s_a_valid and m_d_valid stay asserted, fields stable.
4. Timeout: TIMEOUT=16, slave never responds -> ERR response with d_error=1, opcode 1, source echoed. A late slave response arriving afterwards is consumed in DRAIN and not forwarded.
5. Reset mid-RESP: RST_N pulled low -> all valids 0 immediately; after release, a new request from master 1 is granted normally.
6. Protocol violation: master 0 drops a_valid in ADDR -> back to IDLE, rr_ptr unchanged, s_a_valid follows low.
